// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and the queue entry type shared by the instruction fetch stage.
// The entry fields are sized for the widest supported PC and instruction (32 bits).
// Narrower ADDR_W / INST_W builds zero-extend into them.
package fetch_pkg;

  // Every instruction is one 32-bit word, so the PC always advances by four bytes.
  localparam int INST_BYTES   = 4;

  // Field widths of a queued entry.
  localparam int ENTRY_PC_W   = 32;
  localparam int ENTRY_INST_W = 32;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO of fetch_entry_t with push, pop, flush and occupancy.
// Full and empty are told apart by the extra wrap bit on each pointer, so DEPTH must be a
// power of two (>= 2). A push and a pop in the same cycle are allowed even when the queue
// is full: the slot being vacated by the pop is the one the push writes.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PTR_W:0] wrPtr_q, wrPtr_d;
  logic [PTR_W:0] rdPtr_q, rdPtr_d;
  logic           doPush;
  logic           doPop;

  // Status flags and the accepted push/pop strobes for this cycle.
  always_comb begin
    empty_o = (wrPtr_q == rdPtr_q);
    full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
              (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    count_o = CNT_W'(wrPtr_q - rdPtr_q);
    doPop   = pop_i & ~empty_o;
    doPush  = push_i & (~full_o | doPop);
    head_o  = mem_q[rdPtr_q[PTR_W-1:0]];
  end

  // Pointer update: a flush empties the queue and overrides any push or pop.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Entry storage carries no reset; the pointers alone decide which slots are live.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i && !rst_i) begin
      mem_q[wrPtr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues pipelined reads to instruction
// memory, buffers returned words in a prefetch queue and presents {pc, inst} to decode over
// a valid/ready handshake. A redirect flushes the queue and discards responses that were
// still in flight when it happened.
// Optional feature: define FETCH_PERF_EN to add the fetch_cnt_o delivered-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o
`endif
);

  localparam int                CNT_W         = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP       = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK    = ~ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_WORD = RESET_PC & ALIGN_MASK;
  localparam logic [CNT_W:0]    CREDIT_LIMIT  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);

  logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
  logic [ADDR_W-1:0] respPc_q, respPc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [ADDR_W-1:0] redirectTarget;
  logic [CNT_W:0]    creditUsed;
  logic [CNT_W-1:0]  queueCount;
  logic              queueEmpty;
  logic              queueFull;
  logic              issue;
  logic              respAccept;
  logic              respDrop;
  logic              pushFire;
  logic              popFire;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;

  // Issue, response and handshake decisions. Credits (queued + in flight) never exceed
  // DEPTH, so every response accepted here is guaranteed a free queue slot.
  always_comb begin
    redirectTarget = redirect_pc_i & ALIGN_MASK;
    creditUsed     = {1'b0, queueCount} + {1'b0, outstanding_q};
    issue          = start_i & ~rst_i & ~redirect_i & (creditUsed < CREDIT_LIMIT);
    respAccept     = imem_rvalid_i & (outstanding_q != '0);
    respDrop       = respAccept & (redirect_i | (discard_q != '0));
    pushFire       = respAccept & ~respDrop;
    popFire        = ~queueEmpty & inst_ready_i & ~redirect_i;
    pushEntry.pc   = ENTRY_PC_W'(respPc_q);
    pushEntry.inst = ENTRY_INST_W'(imem_rdata_i);
  end

  // Next-state for the PCs and the in-flight / discard counters; redirect takes priority.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(respAccept);
    if (redirect_i) begin
      fetchPc_d = redirectTarget;
      respPc_d  = redirectTarget;
      discard_d = outstanding_q - CNT_W'(respAccept);
    end else begin
      if (issue)    fetchPc_d = fetchPc_q + PC_STEP;
      if (pushFire) respPc_d  = respPc_q + PC_STEP;
      if (respAccept && (discard_q != '0)) discard_d = discard_q - CNT_ONE;
    end
  end

  // PC and counter registers; reset overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetchPc_q     <= RESET_PC_WORD;
      respPc_q      <= RESET_PC_WORD;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (pushFire),
    .push_data_i (pushEntry),
    .pop_i       (popFire),
    .head_o      (headEntry),
    .empty_o     (queueEmpty),
    .full_o      (queueFull),
    .count_o     (queueCount)
  );

  assign imem_req_o   = issue;
  assign imem_addr_o  = fetchPc_q;
  assign inst_valid_o = ~queueEmpty;
  assign inst_o       = INST_W'(headEntry.inst);
  assign inst_pc_o    = ADDR_W'(headEntry.pc);

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt_q;

  // Delivered-instruction counter: one per accepted pop, wraps naturally, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetchCnt_q <= '0;
    end else if (popFire) begin
      fetchCnt_q <= fetchCnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetchCnt_q;
`endif

  // Memory must never answer when nothing is in flight; such a response is ignored.
  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (outstanding_q != '0));

  // The credit scheme must never let a push land in a full queue without a matching pop.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    pushFire |-> (!queueFull || popFire));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a small in-order
// instruction memory model whose latency can be set to 1..4 cycles.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstIn        = 1'b1;
  logic        startIn      = 1'b0;
  logic        readyIn      = 1'b0;
  logic        redirectIn   = 1'b0;
  logic [31:0] redirectPcIn = 32'h0;

  logic        reqOut;
  logic [31:0] addrOut;
  logic        rvalidIn;
  logic [31:0] rdataIn;
  logic        validOut;
  logic [31:0] instOut;
  logic [31:0] pcOut;
`ifdef FETCH_PERF_EN
  logic [31:0] fetchCntOut;
`endif

  int errorCount = 0;
  int checkCount = 0;
  int reqCount   = 0;

  logic [31:0] popPc[$];
  logic [31:0] popInst[$];

  logic [3:0]       pipeValid = '0;
  logic [3:0][31:0] pipeAddr  = '0;
  logic [1:0]       latSel    = 2'd0;

  fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rstIn),
    .start_i       (startIn),
    .imem_req_o    (reqOut),
    .imem_addr_o   (addrOut),
    .imem_rvalid_i (rvalidIn),
    .imem_rdata_i  (rdataIn),
    .inst_valid_o  (validOut),
    .inst_o        (instOut),
    .inst_pc_o     (pcOut),
    .inst_ready_i  (readyIn),
    .redirect_i    (redirectIn),
    .redirect_pc_i (redirectPcIn)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o   (fetchCntOut)
`endif
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory model: every request reappears as a response latSel+1 cycles later, in order.
  always @(posedge clk) begin
    if (rstIn) begin
      pipeValid <= '0;
    end else begin
      pipeValid <= {pipeValid[2:0], reqOut};
      pipeAddr  <= {pipeAddr[2:0], addrOut};
    end
  end

  assign rvalidIn = pipeValid[latSel];
  assign rdataIn  = memWord(pipeAddr[latSel]);

  task automatic applyStimulus(input logic rst, input logic start, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rstIn        = rst;
    startIn      = start;
    readyIn      = ready;
    redirectIn   = redir;
    redirectPcIn = rpc;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic resetDut(input int lat);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    latSel = 2'(lat - 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clearLog();
    popPc.delete();
    popInst.delete();
    reqCount = 0;
  endtask

  function automatic logic [31:0] pcAt(input int i);
    return (popPc.size() > i) ? popPc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] instAt(input int i);
    return (popInst.size() > i) ? popInst[i] : 32'hDEAD_BEEF;
  endfunction

  // Runs a fixed window with constant inputs, logging requests and accepted instructions.
  task automatic runCycles(input int cycles, input logic start, input logic ready);
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(1'b0, start, ready, 1'b0, 32'h0);
      if (reqOut) reqCount++;
      if (validOut && ready) begin
        popPc.push_back(pcOut);
        popInst.push_back(instOut);
      end
    end
  endtask

  task automatic testStreaming();
    resetDut(1);
    checkOutput("reset req", 32'(reqOut), 32'h0);
    checkOutput("reset valid", 32'(validOut), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t1 c0 req", 32'(reqOut), 32'h1);
    checkOutput("t1 c0 addr", addrOut, 32'h0);
    checkOutput("t1 c0 valid", 32'(validOut), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t1 c1 addr", addrOut, 32'h4);
    checkOutput("t1 c1 valid", 32'(validOut), 32'h0);
    for (int k = 2; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("t1 valid", 32'(validOut), 32'h1);
      checkOutput("t1 pc", pcOut, 32'(4 * (k - 2)));
      checkOutput("t1 inst", instOut, memWord(32'(4 * (k - 2))));
      checkOutput("t1 addr", addrOut, 32'(4 * k));
    end
  endtask

  task automatic testBackpressure();
    resetDut(3);
    clearLog();
    runCycles(10, 1'b1, 1'b0);
    checkOutput("t2 req count", 32'(reqCount), 32'd4);
    checkOutput("t2 stalled req", 32'(reqOut), 32'h0);
    checkOutput("t2 head valid", 32'(validOut), 32'h1);
    checkOutput("t2 head pc", pcOut, 32'h0);
    clearLog();
    runCycles(20, 1'b1, 1'b1);
    checkOutput("t2 enough pops", 32'(popPc.size() >= 8), 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2 pop pc", pcAt(i), 32'(4 * i));
    end
    checkOutput("t2 pop inst", instAt(5), memWord(32'h14));
  endtask

  task automatic testRedirect();
    resetDut(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("t3 redirect req", 32'(reqOut), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3 new req", 32'(reqOut), 32'h1);
    checkOutput("t3 new addr", addrOut, 32'h100);
    clearLog();
    runCycles(12, 1'b1, 1'b1);
    checkOutput("t3 first pc", pcAt(0), 32'h100);
    checkOutput("t3 first inst", instAt(0), memWord(32'h100));
    checkOutput("t3 second pc", pcAt(1), 32'h104);
    checkOutput("t3 third pc", pcAt(2), 32'h108);

    resetDut(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3b addr", addrOut, 32'h80);
    clearLog();
    runCycles(12, 1'b1, 1'b1);
    checkOutput("t3b first pc", pcAt(0), 32'h80);
    checkOutput("t3b second pc", pcAt(1), 32'h84);
  endtask

  task automatic testAlignedRedirect();
    resetDut(1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h203);
    checkOutput("t4 redirect req", 32'(reqOut), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4 addr", addrOut, 32'h200);
    checkOutput("t4 req", 32'(reqOut), 32'h1);
    checkOutput("t4 flushed", 32'(validOut), 32'h0);
    clearLog();
    runCycles(6, 1'b1, 1'b1);
    checkOutput("t4 first pc", pcAt(0), 32'h200);
    checkOutput("t4 second pc", pcAt(1), 32'h204);
  endtask

  task automatic testStopAndWrap();
    resetDut(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5 addr fff8", addrOut, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5 addr fffc", addrOut, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5 addr wrap", addrOut, 32'h0);
    clearLog();
    runCycles(12, 1'b0, 1'b1);
    checkOutput("t5 no req", 32'(reqCount), 32'd0);
    checkOutput("t5 pops", 32'(popPc.size()), 32'd3);
    checkOutput("t5 pc0", pcAt(0), 32'hFFFF_FFF8);
    checkOutput("t5 pc1", pcAt(1), 32'hFFFF_FFFC);
    checkOutput("t5 pc2", pcAt(2), 32'h0);
    checkOutput("t5 inst2", instAt(2), memWord(32'h0));
    checkOutput("t5 drained", 32'(validOut), 32'h0);
  endtask

`ifdef FETCH_PERF_EN
  task automatic testPerfCounter();
    int  pops;
    bit  didRedir;
    logic redir;
    pops     = 0;
    didRedir = 1'b0;
    resetDut(1);
    for (int c = 0; c < 60 && pops < 10; c++) begin
      redir = (pops == 5) && !didRedir;
      applyStimulus(1'b0, 1'b1, 1'b1, redir, 32'h300);
      if (redir) didRedir = 1'b1;
      else if (validOut) pops++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6 pops seen", 32'(pops), 32'd10);
    checkOutput("t6 fetch cnt", fetchCntOut, 32'd10);
  endtask
`endif

  task automatic testMidRunReset();
    resetDut(1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst gate req", 32'(reqOut), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst mid valid", 32'(validOut), 32'h0);
    checkOutput("rst mid req", 32'(reqOut), 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("rst mid cnt", fetchCntOut, 32'h0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rst restart addr", addrOut, 32'h0);
    checkOutput("rst restart req", 32'(reqOut), 32'h1);
  endtask

  // Watchdog: the directed sequence is short, so this only fires if something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] fetch_unit directed test start");
    testStreaming();
    testBackpressure();
    testRedirect();
    testAlignedRedirect();
    testStopAndWrap();
`ifdef FETCH_PERF_EN
    testPerfCounter();
`endif
    testMidRunReset();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
